// File: rtl/sxr_sw_debounce.sv
// ============================================================================
// Module      : sxr_sw_debounce
// Description : Slide-switch conditioner for the sxrRISC621 SW_in port.
//               Each raw switch is passed through a 2-flop synchroniser and
//               a per-bit stability counter before reaching SW_out. Accepted
//               transitions (either direction) can be latched into a sticky
//               pending register that firmware clears with Ack.
// Options     : `define SXR_SW_EDGE_EN to build the pending register,
//               SW_event and the Ack handshake. Without it SW_edge and
//               SW_event are tied low and Ack is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sxr_sw_debounce #(
    parameter int DB_CYCLES = 16,
    parameter int CNT_W     = 5
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [4:0] SW_raw,
    output logic [4:0] SW_out,
    output logic [4:0] SW_edge,
    output logic       SW_event,
    input  logic       Ack
);

    // Terminal count: the DB_CYCLES-th consecutive differing sample
    localparam logic [CNT_W-1:0] c_TERM = CNT_W'(DB_CYCLES - 1);

    logic [4:0] w_stable;
    logic [4:0] w_chg;

    genvar gi;
    for (gi = 0; gi < 5; gi++) begin : g_bit
        logic             s1_q;
        logic             s2_q;
        logic             stable_q;
        logic             stable_d;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;
        logic             chg_d;

        // Stability counter: any sample matching the accepted level restarts
        // the count; reaching terminal count accepts the new level.
        always_comb begin
            cnt_d    = '0;
            stable_d = stable_q;
            chg_d    = 1'b0;
            if (s2_q != stable_q) begin
                if (cnt_q == c_TERM) begin
                    stable_d = s2_q;
                    chg_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        // Synchroniser, counter and accepted-level registers
        always_ff @(posedge Clock) begin
            if (Reset) begin
                s1_q     <= 1'b0;
                s2_q     <= 1'b0;
                stable_q <= 1'b0;
                cnt_q    <= '0;
            end else begin
                s1_q     <= SW_raw[gi];
                s2_q     <= s1_q;
                stable_q <= stable_d;
                cnt_q    <= cnt_d;
            end
        end

        assign w_stable[gi] = stable_q;
        assign w_chg[gi]    = chg_d;
    end

    assign SW_out = w_stable;

`ifdef SXR_SW_EDGE_EN
    logic [4:0] edge_q;
    logic [4:0] edge_d;

    // Ack clears old pending bits, but a change accepted this cycle survives
    always_comb begin
        edge_d = (Ack ? 5'b0 : edge_q) | w_chg;
    end

    // Sticky pending-change register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            edge_q <= 5'b0;
        end else begin
            edge_q <= edge_d;
        end
    end

    assign SW_edge  = edge_q;
    assign SW_event = |edge_q;
`else
    logic w_unused;
    assign w_unused = ^{Ack, w_chg};
    assign SW_edge  = 5'b0;
    assign SW_event = 1'b0;
`endif

endmodule

`default_nettype wire
